// File: rtl/iir_pkg.sv
// iir_pkg: coefficient indices, FSM/MAC encodings and the DW reduction (saturating when IIR_SAT_EN is defined)
package iir_pkg;
  localparam logic [2:0] B0 = 3'd0, B1 = 3'd1, B2 = 3'd2, A1 = 3'd3, A2 = 3'd4;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  typedef enum logic [1:0] {OP_PRE_SUB, OP_SUB, OP_LOAD, OP_ADD} mac_op_t;
  function automatic logic signed [127:0] reduce_dw(input logic signed [127:0] v, input int dw);
`ifdef IIR_SAT_EN
    logic signed [127:0] hi;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    return v > hi ? hi : v < -hi - 128'sd1 ? -hi - 128'sd1 : v;
`else
    return (v <<< (128 - dw)) >>> (128 - dw);
`endif
  endfunction
endpackage

// File: rtl/iir_mac.sv
// iir_mac: signed DWxCW multiply with preset/subtract/load/add accumulate and shift-and-reduce output
module iir_mac import iir_pkg::*; #(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int FRAC = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  mac_op_t              i_op,
  input  logic signed [DW-1:0] i_pre,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [CW-1:0] i_b,
  output logic signed [DW-1:0] o_red
);
  localparam int AW = DW + CW + 3;
  logic signed [AW-1:0] r_acc, w_prod, w_nxt;
  assign w_prod = AW'(i_a) * AW'(i_b);
  always_comb
    w_nxt = i_op == OP_PRE_SUB ? (AW'(i_pre) <<< FRAC) - w_prod :
            i_op == OP_SUB     ? r_acc - w_prod :
            i_op == OP_LOAD    ? w_prod : r_acc + w_prod;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_acc <= '0;
    else if (i_en) r_acc <= w_nxt;
  assign o_red = DW'(reduce_dw(128'(r_acc >>> FRAC), DW));
endmodule

// File: rtl/iir_sos_engine.sv
// iir_sos_engine: time-multiplexed NSEC-section DF-II IIR over NCH channels; define IIR_SAT_EN for saturating reduction
module iir_sos_engine import iir_pkg::*; #(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int FRAC = 25,
  parameter int NSEC = 3,
  parameter int NCH = 3,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int SECW = NSEC > 1 ? $clog2(NSEC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic [CHW-1:0]            x_ch,
  input  logic signed [DW-1:0]      x,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [CHW-1:0]            y_ch,
  output logic signed [DW-1:0]      y,
  input  logic                      cfg_we,
  input  logic [CHW+SECW+2:0]       cfg_addr,
  input  logic signed [CW-1:0]      cfg_data,
  output logic                      busy
);
  localparam int NS = NCH * NSEC;
  localparam int SIW = NS > 1 ? $clog2(NS) : 1;
  localparam int CIW = $clog2(NS * 5);
  localparam logic signed [CW-1:0] ONE = CW'(1) <<< FRAC;
  state_t r_state;
  logic [2:0] r_step, w_idx, w_cfg_idx;
  logic [SECW-1:0] r_sec, w_cfg_sec;
  logic [CHW-1:0] r_ch, r_y_ch, w_cfg_ch;
  logic signed [DW-1:0] r_x, r_w, r_y, w_red, w_a;
  logic r_y_valid, w_cfg_ok;
  logic signed [CW-1:0] r_coef [NS*5];
  logic signed [DW-1:0] r_w1 [NS];
  logic signed [DW-1:0] r_w2 [NS];
  logic [SIW-1:0] w_si;
  logic [CIW-1:0] w_ci, w_cfg_ci;
  mac_op_t w_op;
  assign {w_cfg_ch, w_cfg_sec, w_cfg_idx} = cfg_addr;
  assign w_cfg_ok = cfg_we && r_state == IDLE && w_cfg_idx <= A2 && int'(w_cfg_ch) < NCH && int'(w_cfg_sec) < NSEC;
  assign w_cfg_ci = CIW'((int'(w_cfg_ch) * NSEC + int'(w_cfg_sec)) * 5 + int'(w_cfg_idx));
  assign w_si = SIW'(int'(r_ch) * NSEC + int'(r_sec));
  assign w_ci = CIW'(int'(w_si) * 5 + int'(w_idx));
  // steps 0-1 build w from the feedback taps, steps 2-4 build the section output; step 5 only drains the last section
  always_comb begin
    w_idx = r_step == 3'd0 ? A1 : r_step == 3'd1 ? A2 : r_step == 3'd2 ? B0 : r_step == 3'd3 ? B1 : B2;
    w_op = r_step == 3'd0 ? OP_PRE_SUB : r_step == 3'd1 ? OP_SUB : r_step == 3'd2 ? OP_LOAD : OP_ADD;
    w_a = (r_step == 3'd0 || r_step == 3'd3) ? r_w1[w_si] : r_step == 3'd2 ? w_red : r_w2[w_si];
  end
  iir_mac #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_mac (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state == MAC && r_step != 3'd5),
    .i_op  (w_op),
    .i_pre (r_sec == '0 ? r_x : w_red),
    .i_a   (w_a),
    .i_b   (r_coef[w_ci]),
    .o_red (w_red)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_step <= '0;
      r_sec <= '0;
      r_ch <= '0;
      r_x <= '0;
      r_w <= '0;
      r_y <= '0;
      r_y_ch <= '0;
      r_y_valid <= 1'b0;
      for (int i = 0; i < NS * 5; i++) r_coef[i] <= i % 5 == int'(B0) ? ONE : '0;
      for (int i = 0; i < NS; i++) begin
        r_w1[i] <= '0;
        r_w2[i] <= '0;
      end
    end else begin
      if (w_cfg_ok) r_coef[w_cfg_ci] <= cfg_data;
      if (r_state == IDLE && x_valid) begin
        r_x <= x;
        r_ch <= x_ch;
        r_sec <= '0;
        r_step <= '0;
        r_state <= MAC;
      end
      if (r_state == MAC) begin
        if (r_step == 3'd2) r_w <= w_red;
        if (r_step == 3'd4) begin
          r_w1[w_si] <= r_w;
          r_w2[w_si] <= r_w1[w_si];
        end
        if (r_step == 3'd5) begin
          r_state <= OUT;
          r_y <= w_red;
          r_y_ch <= r_ch;
          r_y_valid <= 1'b1;
        end else if (r_step == 3'd4 && int'(r_sec) != NSEC - 1) begin
          r_sec <= r_sec + SECW'(1);
          r_step <= '0;
        end else r_step <= r_step + 3'd1;
      end
      if (r_state == OUT && y_ready) begin
        r_y_valid <= 1'b0;
        r_state <= IDLE;
      end
    end
  assign x_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign y_valid = r_y_valid;
  assign y = r_y;
  assign y_ch = r_y_ch;
endmodule

// File: tb/tb_iir_sos_engine.sv
// tb_iir_sos_engine: directed vectors with hand-computed results for iir_sos_engine at default parameters
module tb_iir_sos_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x_valid = 1'b0, y_ready = 1'b0, cfg_we = 1'b0;
  logic x_ready, y_valid, busy;
  logic [1:0] x_ch, y_ch;
  logic signed [31:0] x, y, cfg_data;
  logic [6:0] cfg_addr;
  int checks = 0, errors = 0;
  logic ok;
  always #5 clk = ~clk;
  iir_sos_engine dut (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x_ready(x_ready), .x_ch(x_ch), .x(x),
    .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch), .y(y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
  );
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cfg(input int ch, input int sec, input int idx, input logic signed [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = {2'(ch), 2'(sec), 3'(idx)};
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask
  task automatic accept(input int ch, input logic signed [31:0] v);
    x_valid = 1'b1;
    x_ch = 2'(ch);
    x = v;
    @(posedge clk);
    #1 x_valid = 1'b0;
  endtask
  task automatic wait_y(input string tag, input int ch, input logic signed [31:0] exp);
    int n = 0, nb = 0;
    while (!y_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (busy) nb++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_busy"}, nb, n);
    chk({tag, "_y"}, y, exp);
    chk({tag, "_ch"}, y_ch, ch);
  endtask
  task automatic handshake;
    y_ready = 1'b1;
    @(posedge clk);
    #1 y_ready = 1'b0;
  endtask
  task automatic run(input string tag, input int ch, input logic signed [31:0] v, input logic signed [31:0] exp);
    accept(ch, v);
    wait_y(tag, ch, exp);
    handshake();
  endtask
  initial begin
    x_ch = '0;
    x = '0;
    cfg_addr = '0;
    cfg_data = '0;
    #2 reset = 1'b0;
    #10;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_y_ch", y_ch, 0);
    chk("rst_x_ready", x_ready, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run("ident", 0, 1000, 1000);
    cfg(1, 0, 0, 67108864);
    run("gain1", 1, -300, -600);
    run("gain0", 0, -300, -300);
    cfg(0, 0, 5, 67108864);
    run("badidx", 0, -300, -300);
    run("zero_a", 0, 0, 0);
    run("zero_b", 0, 0, 0);
    cfg(0, 0, 3, -16777216);
    run("rec0", 0, 1024, 1024);
    run("rec1", 0, 0, 512);
    run("rec2", 0, 0, 256);
    run("rec3", 0, 0, 128);
    run("rec4", 0, 0, 64);
    cfg(0, 0, 3, 0);
    cfg_we = 1'b1;
    cfg_addr = {2'd0, 2'd0, 3'd0};
    cfg_data = 67108864;
    accept(0, 32'h7FFFFFF0);
    cfg_we = 1'b0;
`ifdef IIR_SAT_EN
    wait_y("ovf", 0, 32'h7FFFFFFF);
`else
    wait_y("ovf", 0, -32);
`endif
    handshake();
    accept(1, 7);
    wait_y("bp", 1, 14);
    cfg_we = 1'b1;
    cfg_addr = {2'd1, 2'd0, 3'd0};
    cfg_data = 100663296;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 ok = ok && y_valid && y == 14 && y_ch == 2'd1 && !x_ready;
    end
    cfg_we = 1'b0;
    chk("bp_hold", ok, 1);
    handshake();
    chk("bp_hs_valid", y_valid, 0);
    chk("bp_hs_ready", x_ready, 1);
    accept(1, 7);
    chk("bp_next_busy", busy, 1);
    wait_y("bp_next", 1, 14);
    handshake();
    accept(0, 100);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_y_valid", y_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_y", y, 0);
    chk("mid_x_ready", x_ready, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run("post1", 1, 5, 5);
    run("post0", 0, 100, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
